dbg_slave_cmd_queue: RTL and testbench

//  System-clock side of the JTAG debug slave, parametrised successor of the single-register sysclk stage.

---
 rtl/dbg_slave_cmd_queue.sv | 105 ++++++++++
 tb/tb_dbg_slave_cmd_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_slave_cmd_queue.sv
// dbg_slave_cmd_queue: sysclk side of the JTAG debug slave; synchronises TCK strobes and queues {ir,sr} commands
// Optional DBG_CMD_PARITY_EN: sr[SR_W-1] is odd parity over {ir_in, sr[SR_W-2:0]}; bad captures are counted and dropped
module dbg_slave_cmd_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_e1dr_async,
  input  logic                   vs_uir_async,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [SR_W-1:0]        sr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [SR_W-1:0]        cmd_data,
  output logic [SR_W-1:0]        jdo,
  output logic                   ir_update,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [7:0]             perr_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int ARM = SYNC_STAGES + 1;
  localparam int AW = $clog2(ARM + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [AW-1:0] ARMED = AW'(ARM);
  logic [SYNC_STAGES-1:0] e1_sync_q, uir_sync_q;
  logic e1_prev_q, uir_prev_q, uir_pulse_q;
  logic [AW-1:0] arm_q, arm_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic ovf_q, ovf_d;
  logic [SR_W-1:0] jdo_q, jdo_d;
  logic [IR_W+SR_W-1:0] mem_q [DEPTH];
  logic armed, e1_rise, uir_rise, par_ok, push_req, push, pop, full;
  assign armed = arm_q == ARMED;
  assign e1_rise = armed && e1_sync_q[SYNC_STAGES-1] && !e1_prev_q;
  assign uir_rise = armed && uir_sync_q[SYNC_STAGES-1] && !uir_prev_q;
  assign full = level_q == FULL;
  assign cmd_valid = level_q != '0;
  assign pop = cmd_valid && cmd_ready;
  assign push_req = e1_rise && par_ok;
  assign push = push_req && (!full || pop);
  assign {cmd_ir, cmd_data} = mem_q[rptr_q];
  assign jdo = jdo_q;
  assign ir_update = uir_pulse_q;
  assign fifo_level = level_q;
  assign overflow = ovf_q;
`ifdef DBG_CMD_PARITY_EN
  logic [7:0] perr_q;
  assign par_ok = ^{ir_in, sr};
  assign perr_count = perr_q;
  // count captures dropped for bad parity, saturating at 255
  always_ff @(posedge clk)
    perr_q <= !reset_n ? '0 : (e1_rise && !par_ok && perr_q != 8'hFF) ? perr_q + 8'd1 : perr_q;
`else
  assign par_ok = 1'b1;
  assign perr_count = '0;
`endif
  // next state: arm countdown, pointer/level bookkeeping, sticky overflow (set beats clear), jdo latch on pop
  always_comb begin
    arm_d = armed ? arm_q : arm_q + AW'(1);
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    ovf_d = (push_req && full && !pop) || (ovf_q && !overflow_clr);
    jdo_d = pop ? cmd_data : jdo_q;
  end
  // synchronisers, edge history and queue control state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e1_sync_q <= '0;
      uir_sync_q <= '0;
      e1_prev_q <= 1'b0;
      uir_prev_q <= 1'b0;
      uir_pulse_q <= 1'b0;
      arm_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      jdo_q <= '0;
    end else begin
      e1_sync_q <= {e1_sync_q[SYNC_STAGES-2:0], vs_e1dr_async};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_async};
      e1_prev_q <= e1_sync_q[SYNC_STAGES-1];
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      uir_pulse_q <= uir_rise;
      arm_q <= arm_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      jdo_q <= jdo_d;
    end
  end
  // command storage, written with the inputs present on the push edge; contents survive reset
  always_ff @(posedge clk)
    if (reset_n && push) mem_q[wptr_q] <= {ir_in, sr};
endmodule

// File: tb/tb_dbg_slave_cmd_queue.sv
// tb_dbg_slave_cmd_queue: directed scenarios plus random traffic against a queue-based reference model
module tb_dbg_slave_cmd_queue;
  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int DEPTH = 4;
  localparam int S = 2;
  typedef logic [IR_W+SR_W-1:0] ent_t;
  logic clk = 1'b0, reset_n = 1'b0, vs_e1dr_async = 1'b0, vs_uir_async = 1'b0;
  logic cmd_ready = 1'b0, overflow_clr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic cmd_valid, ir_update, overflow;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data, jdo;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] perr_count;
  int total = 0, bad = 0;
  ent_t mq[$];
  bit es[$], us[$];
  int n_m = 0, perr_m = 0;
  logic [SR_W-1:0] jdo_m = '0;
  bit ovf_m = 0, upd_m = 0, chk_en = 0;
  always #5 clk = ~clk;
  dbg_slave_cmd_queue #(.SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .vs_e1dr_async(vs_e1dr_async), .vs_uir_async(vs_uir_async),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .jdo(jdo), .ir_update(ir_update), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr), .perr_count(perr_count)
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [SR_W-1:0] fixp(input logic [IR_W-1:0] i, input logic [SR_W-1:0] s);
`ifdef DBG_CMD_PARITY_EN
    s[SR_W-1] = ~^{i, s[SR_W-2:0]};
`endif
    return s;
  endfunction
  // reference model: a capture lands S edges after the first high sample, once S+1 post-reset edges have passed
  always @(posedge clk) begin : model
    bit er, ur, pp, good;
    ent_t h;
    if (!reset_n) begin
      n_m = 0;
      es = {1'b0};
      us = {1'b0};
      mq.delete();
      jdo_m = '0;
      ovf_m = 0;
      upd_m = 0;
      perr_m = 0;
    end else begin
      n_m++;
      es.push_back(vs_e1dr_async);
      us.push_back(vs_uir_async);
      er = n_m >= S + 2 && es[n_m-S] && !es[n_m-S-1];
      ur = n_m >= S + 2 && us[n_m-S] && !us[n_m-S-1];
      upd_m = ur;
      pp = mq.size() > 0 && cmd_ready;
      if (pp) begin
        h = mq.pop_front();
        jdo_m = h[SR_W-1:0];
      end
      if (overflow_clr) ovf_m = 0;
`ifdef DBG_CMD_PARITY_EN
      good = ^{ir_in, sr};
`else
      good = 1;
`endif
      if (er) begin
        if (!good) perr_m = perr_m < 255 ? perr_m + 1 : 255;
        else if (mq.size() < DEPTH) mq.push_back({ir_in, sr});
        else ovf_m = 1;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("level", fifo_level, mq.size());
    check("valid", cmd_valid, mq.size() != 0);
    if (mq.size() != 0) check("head", {cmd_ir, cmd_data}, mq[0]);
    check("jdo", jdo, jdo_m);
    check("overflow", overflow, ovf_m);
    check("ir_update", ir_update, upd_m);
    check("perr", perr_count, perr_m);
  end
  task automatic cap(input logic [IR_W-1:0] i, input logic [SR_W-1:0] d, input bit badp = 0);
    ir_in = i;
    sr = fixp(i, d);
    if (badp) sr[SR_W-1] = ~sr[SR_W-1];
    vs_e1dr_async = 1'b1;
    repeat (4) @(negedge clk);
    vs_e1dr_async = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    logic [SR_W-1:0] v;
    int cnt, pos;
    @(negedge clk);
    chk_en = 1;
    check("rst_level", fifo_level, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_jdo", jdo, 0);
    check("rst_ovf", overflow, 0);
    check("rst_perr", perr_count, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    v = fixp(2'b01, 38'h2A_DEAD_BEEF);
    cmd_ready = 1'b1;
    ir_in = 2'b01;
    sr = v;
    vs_e1dr_async = 1'b1;
    @(negedge clk);
    check("t1_valid_e1", cmd_valid, 0);
    @(negedge clk);
    check("t1_valid_e2", cmd_valid, 0);
    @(negedge clk);
    check("t1_valid_e3", cmd_valid, 1);
    check("t1_data", cmd_data, v);
    check("t1_ir", cmd_ir, 2'b01);
    @(negedge clk);
    check("t1_jdo", jdo, v);
    check("t1_popped", cmd_valid, 0);
    vs_e1dr_async = 1'b0;
    cmd_ready = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 5; i++) cap(2'b10, SR_W'(i));
    check("t2_level", fifo_level, DEPTH);
    check("t2_ovf", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check("t2_order", cmd_data, fixp(2'b10, SR_W'(i)));
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
    end
    check("t2_empty", fifo_level, 0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("t2_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) cap(2'b11, SR_W'(32'h100 + i));
    check("t3_full", fifo_level, DEPTH);
    v = fixp(2'b00, 38'h3_0000_ABCD);
    ir_in = 2'b00;
    sr = v;
    vs_e1dr_async = 1'b1;
    repeat (2) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("t3_level", fifo_level, DEPTH);
    check("t3_ovf", overflow, 0);
    @(negedge clk);
    vs_e1dr_async = 1'b0;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    repeat (4) @(negedge clk);
    cmd_ready = 1'b0;
    check("t3_tail", jdo, v);
    check("t3_drained", fifo_level, 0);
    cap(2'b01, 38'h11);
    cap(2'b01, 38'h22);
    check("t4_queued", fifo_level, 2);
    sr = fixp(2'b01, 38'h33);
    vs_e1dr_async = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_level", fifo_level, 0);
    check("t4_valid", cmd_valid, 0);
    vs_e1dr_async = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_still_empty", fifo_level, 0);
    cap(2'b01, 38'h44);
    check("t4_recapture", fifo_level, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    cnt = 0;
    pos = 0;
    vs_uir_async = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 10) vs_uir_async = 1'b0;
      if (ir_update) begin
        cnt++;
        pos = k;
      end
    end
    check("t5_pulses", cnt, 1);
    check("t5_latency", pos, 3);
`ifdef DBG_CMD_PARITY_EN
    for (int i = 0; i < 3; i++) cap(2'b10, SR_W'(i + 7), 1);
    cap(2'b10, 38'h55);
    check("t6_perr", perr_count, 3);
    check("t6_level", fifo_level, 1);
    check("t6_ovf", overflow, 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
`endif
    for (int c = 0; c < 2000; c++) begin
      if (!vs_e1dr_async) begin
        if ($urandom_range(3) == 0) begin
          ir_in = IR_W'($urandom);
          sr = SR_W'({$urandom, $urandom});
          vs_e1dr_async = 1'b1;
        end
      end else if ($urandom_range(2) == 0) vs_e1dr_async = 1'b0;
      if ($urandom_range(4) == 0) vs_uir_async = ~vs_uir_async;
      cmd_ready = $urandom_range(2) == 0;
      overflow_clr = $urandom_range(15) == 0;
      reset_n = $urandom_range(199) != 0;
      @(negedge clk);
    end
    reset_n = 1'b1;
    vs_e1dr_async = 1'b0;
    vs_uir_async = 1'b0;
    overflow_clr = 1'b0;
    cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("final_empty", fifo_level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
